// File: rtl/sar_adc_sequencer_if.sv
// Handshake and analog front-end bundle for the SAR sequencer.
// The slave side is the sequencer; the master side is the system/analog environment.
interface sar_adc_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic         cont;
    logic         abort;
    logic         cmp;
    logic [N-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, cont, abort, cmp,
        input  dac_code, busy, done, result
    );

    modport slave (
        input  start, cont, abort, cmp,
        output dac_code, busy, done, result
    );
endinterface

// File: rtl/sar_adc_sequencer.sv
// Successive-approximation controller: one shared comparator resolves the code MSB first,
// holding each trial code SETTLE extra cycles before sampling the comparator.
module sar_adc_sequencer #(
    parameter int N      = 8,
    parameter int SETTLE = 2
) (
    input logic                clk,
    input logic                rst,
    sar_adc_sequencer_if.slave bus
);
    localparam int            IW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]  MSB_CODE   = {1'b1, {(N-1){1'b0}}};
    localparam logic [IW-1:0] TOP_IDX    = IW'(N - 1);
    localparam logic [3:0]    SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t        r_state, w_nextState;
    logic [N-1:0]  r_dac, w_nextDac;
    logic [N-1:0]  r_result, w_nextResult;
    logic [N-1:0]  w_decided;
    logic [IW-1:0] r_bitIdx, w_nextBitIdx;
    logic [3:0]    r_cnt, w_nextCnt;
    logic          r_busy, w_nextBusy;
    logic          r_done, w_nextDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dac    <= '0;
            r_result <= '0;
            r_bitIdx <= TOP_IDX;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_dac    <= w_nextDac;
            r_result <= w_nextResult;
            r_bitIdx <= w_nextBitIdx;
            r_cnt    <= w_nextCnt;
            r_busy   <= w_nextBusy;
            r_done   <= w_nextDone;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextDac    = r_dac;
        w_nextResult = r_result;
        w_nextBitIdx = r_bitIdx;
        w_nextCnt    = r_cnt;
        w_nextBusy   = 1'b0;
        w_nextDone   = 1'b0;

        // Trial code with the bit under test resolved by the comparator.
        w_decided = r_dac;
        if (!bus.cmp) begin
            w_decided[r_bitIdx] = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_nextState  = CONV;
                    w_nextDac    = MSB_CODE;
                    w_nextBitIdx = TOP_IDX;
                    w_nextCnt    = SETTLE_CNT;
                    w_nextBusy   = 1'b1;
                end
            end
            CONV: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                    w_nextDac   = '0;
                end else if (r_cnt != 4'd0) begin
                    w_nextCnt  = r_cnt - 4'd1;
                    w_nextBusy = 1'b1;
                end else if (r_bitIdx != '0) begin
                    w_nextDac                      = w_decided;
                    w_nextDac[r_bitIdx - 1'b1]     = 1'b1;
                    w_nextBitIdx                   = r_bitIdx - 1'b1;
                    w_nextCnt                      = SETTLE_CNT;
                    w_nextBusy                     = 1'b1;
                end else begin
                    w_nextDac    = w_decided;
                    w_nextResult = w_decided;
                    w_nextState  = DONE;
                    w_nextDone   = 1'b1;
                end
            end
            DONE: begin
                // Continuous mode restarts straight from DONE; start is ignored here.
                if (bus.abort) begin
                    w_nextState = IDLE;
                    w_nextDac   = '0;
                end else if (bus.cont) begin
                    w_nextState  = CONV;
                    w_nextDac    = MSB_CODE;
                    w_nextBitIdx = TOP_IDX;
                    w_nextCnt    = SETTLE_CNT;
                    w_nextBusy   = 1'b1;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign bus.dac_code = r_dac;
    assign bus.result   = r_result;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Self-checking bench for sar_adc_sequencer: ideal-comparator model, scoreboard of expected
// results and done timing for the main instance, plus small-N and noisy-comparator instances.
module tb_sar_adc_sequencer;
    logic clk;
    logic rst;
    int   cyc;
    int   checkCount;
    int   errCount;

    logic [7:0] vin8;
    logic [3:0] vin4;
    logic [3:0] vin43;
    logic       noise43;

    typedef struct {
        logic [7:0] res;
        int         doneCyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;

    sar_adc_sequencer_if #(.N(8)) if8 ();
    sar_adc_sequencer_if #(.N(4)) if4 ();
    sar_adc_sequencer_if #(.N(4)) if43 ();

    sar_adc_sequencer #(.N(8), .SETTLE(2)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    sar_adc_sequencer #(.N(4), .SETTLE(0)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    sar_adc_sequencer #(.N(4), .SETTLE(3)) dut43 (.clk(clk), .rst(rst), .bus(if43));

    // Ideal comparators; the SETTLE=3 instance gets deliberate glitches off decision edges.
    assign if8.cmp  = (vin8 >= if8.dac_code);
    assign if4.cmp  = (vin4 >= if4.dac_code);
    assign if43.cmp = (vin43 >= if43.dac_code) ^ noise43;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("[TB] FAIL watchdog: got cyc=%0d required < 20000", cyc);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", tag, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if8.done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("result", 32'(if8.result), 32'(monExp.res));
                checkOutput("doneCycle", 32'(cyc), 32'(monExp.doneCyc));
                checkOutput("busyInDone", 32'(if8.busy), 32'd0);
            end
        end
    end

    // Pulses start for one edge from a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] v);
        exp_t e;
        vin8      = v;
        e.res     = v;
        e.doneCyc = cyc + 1 + 24;
        expQ.push_back(e);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic convert8(input logic [7:0] v, input bit checkTrials, input bit extraStart);
        logic [7:0] code;
        logic [7:0] trial;
        int         busyCnt;
        applyStimulus(v);
        code    = 8'h00;
        busyCnt = 0;
        for (int b = 7; b >= 0; b--) begin
            trial = code | (8'h01 << b);
            for (int s = 0; s < 3; s++) begin
                if (checkTrials && s == 0) checkOutput("trialCode", 32'(if8.dac_code), 32'(trial));
                if (if8.busy) busyCnt++;
                if8.start = (extraStart && b == 5 && s == 0);
                @(negedge clk);
            end
            if (v >= trial) code = trial;
        end
        if8.start = 1'b0;
        checkOutput("busyCycles", 32'(busyCnt), 32'd24);
        checkOutput("doneHigh", 32'(if8.done), 32'd1);
        @(negedge clk);
        checkOutput("donePulseWidth", 32'(if8.done), 32'd0);
        checkOutput("idleBusy", 32'(if8.busy), 32'd0);
    endtask

    task automatic convertFast(input logic [3:0] v);
        vin4      = v;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fastNoDoneYet", 32'(if4.done), 32'd0);
        end
        @(negedge clk);
        checkOutput("fastDone", 32'(if4.done), 32'd1);
        checkOutput("fastResult", 32'(if4.result), 32'(v));
        @(negedge clk);
    endtask

    task automatic convertNoisy(input logic [3:0] v);
        int e0;
        vin43      = v;
        e0         = cyc + 1;
        if43.start = 1'b1;
        @(negedge clk);
        if43.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            noise43 = (((cyc + 1 - e0) % 4) != 0);
            @(negedge clk);
        end
        noise43 = 1'b0;
        checkOutput("noisyDone", 32'(if43.done), 32'd1);
        checkOutput("noisyResult", 32'(if43.result), 32'(v));
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int lowCnt;
        checkCount = 0;
        errCount   = 0;
        rst        = 1'b1;
        vin8 = 8'h00; vin4 = 4'h0; vin43 = 4'h0; noise43 = 1'b0;
        if8.start  = 1'b0; if8.cont  = 1'b0; if8.abort  = 1'b0;
        if4.start  = 1'b0; if4.cont  = 1'b0; if4.abort  = 1'b0;
        if43.start = 1'b0; if43.cont = 1'b0; if43.abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstDac", 32'(if8.dac_code), 32'd0);
        checkOutput("rstBusy", 32'(if8.busy), 32'd0);
        checkOutput("rstDone", 32'(if8.done), 32'd0);
        checkOutput("rstResult", 32'(if8.result), 32'd0);

        $display("[TB] ideal conversion and extremes");
        convert8(8'hA5, 1'b1, 1'b0);
        convert8(8'hFF, 1'b0, 1'b0);
        convert8(8'h00, 1'b1, 1'b0);
        convert8(8'h80, 1'b0, 1'b0);

        $display("[TB] continuous mode");
        vin8 = 8'h3C;
        if8.cont = 1'b1;
        applyStimulus(8'h3C);
        e0 = cyc;
        monExp.res = 8'h71;
        monExp.doneCyc = e0 + 49;
        expQ.push_back(monExp);
        lowCnt = 0;
        for (int i = 0; i < 49; i++) begin
            if (!if8.busy) lowCnt++;
            if (i == 25) begin
                vin8     = 8'h71;
                if8.cont = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("contBusyLowCycles", 32'(lowCnt), 32'd1);
        checkOutput("contSecondDone", 32'(if8.done), 32'd1);
        @(negedge clk);
        checkOutput("contIdleAfter", 32'(if8.busy), 32'd0);

        $display("[TB] start while busy, then abort");
        convert8(8'h5A, 1'b0, 1'b1);
        convert8(8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h5A);
        repeat (10) @(negedge clk);
        checkOutput("abortBit4Trial", 32'(if8.dac_code), 32'h50);
        if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        void'(expQ.pop_back());
        checkOutput("abortBusy", 32'(if8.busy), 32'd0);
        checkOutput("abortDac", 32'(if8.dac_code), 32'd0);
        checkOutput("abortDone", 32'(if8.done), 32'd0);
        checkOutput("abortResult", 32'(if8.result), 32'h3C);
        repeat (30) @(negedge clk);
        checkOutput("abortResultHeld", 32'(if8.result), 32'h3C);

        $display("[TB] reset mid-conversion and with start");
        applyStimulus(8'h77);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(expQ.pop_back());
        checkOutput("midRstDac", 32'(if8.dac_code), 32'd0);
        checkOutput("midRstBusy", 32'(if8.busy), 32'd0);
        checkOutput("midRstResult", 32'(if8.result), 32'd0);
        rst = 1'b1;
        if8.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if8.start = 1'b0;
        checkOutput("rstStartBusy", 32'(if8.busy), 32'd0);
        checkOutput("rstStartDac", 32'(if8.dac_code), 32'd0);
        @(negedge clk);
        checkOutput("rstStartStillIdle", 32'(if8.busy), 32'd0);
        convert8(8'hC3, 1'b1, 1'b0);

        $display("[TB] N=4 SETTLE=0 and SETTLE=3 with comparator glitches");
        convertFast(4'h9);
        convertFast(4'hF);
        convertFast(4'h0);
        convertNoisy(4'h6);
        convertNoisy(4'hB);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/sar_adc_sequencer.md
Name: sar_adc_sequencer

Overview:
- Sequential successive-approximation controller for the team's binary-search ADC: resolves one bit per step using a single external comparator and a trial-code DAC, MSB first.
- Replaces the combinational mux/comparator chain with one shared comparator, time-multiplexed over N steps.
- Sits between the system control logic (start/done handshake) and the analog front end (DAC code out, comparator bit in).

Parameters:
N, 8, result width in bits (legal 2..16)
SETTLE, 2, extra cycles each trial code is held before the comparator is sampled (legal 0..15)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE
cont  input  1  continuous mode; sampled at the end of each conversion
abort  input  1  cancel the conversion in progress; priority over start and cont
cmp  input  1  comparator result: 1 = vin >= DAC(dac_code), 0 = vin < DAC(dac_code)
dac_code  output  N  trial code driven to the DAC
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: result updated
result  output  N  last completed conversion value, held until the next completion

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, dac_code=0, busy=0, done=0, result=0, bit_idx=N-1, cnt=0. Reset applies from any state, including mid-conversion; no done pulse is produced.
- States: IDLE, CONV, DONE. All outputs are registered.
- IDLE:
  - busy=0, done=0, dac_code holds its last value.
  - On start=1 and abort=0: go to CONV, dac_code=1<<(N-1), bit_idx=N-1, cnt=SETTLE.
- CONV:
  - busy=1.
  - If cnt!=0: cnt decrements and dac_code is held.
  - If cnt==0, the decision edge:
    - If cmp=0, clear dac_code[bit_idx]; if cmp=1, keep it.
    - If bit_idx!=0: set dac_code[bit_idx-1], decrement bit_idx, reload cnt=SETTLE.
    - If bit_idx==0: result=final code (including the bit-0 decision), go to DONE.
- Timing:
  - Each bit occupies SETTLE+1 cycles.
  - cmp is sampled only at decision edges, SETTLE+1 edges after the trial bit was set.
  - done rises exactly N*(SETTLE+1) edges after the edge that accepted start.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next state: if cont=1 and abort=0, restart as if start were accepted (CONV, dac_code=1<<(N-1), cnt=SETTLE). Otherwise go to IDLE. A start pulse in DONE is ignored.
- abort=1 in CONV or DONE: go to IDLE at that edge, busy=0, done=0, result unchanged, dac_code=0. abort in IDLE does nothing.
- start while busy is ignored; it is not queued.
- Boundary cases:
  - cmp=1 on all steps: result = all ones.
  - cmp=0 on all steps: result = 0.
  - SETTLE=0: one bit per cycle, N-cycle conversion.
- No arithmetic beyond bit set/clear; cnt is 4 bits and bit_idx is ceil(log2 N) bits. No wrap-around is possible within legal parameters.

Test Plan:
1. Ideal-comparator model (cmp = vin >= dac_code), N=8, SETTLE=2, vin=0xA5, start pulse -> busy for 24 cycles; dac_code steps through 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; done pulses one cycle 24 edges after start; result=0xA5.
2. Extremes: vin=0xFF -> result=0xFF; vin=0x00 -> result=0x00, with the trial code sequence 0x80, 0x40, …, 0x01. Also check result=0x80 for vin=0x80.
3. Continuous mode: cont=1, vin=0x3C then vin changed to 0x71 during the second conversion's MSB step -> results 0x3C then 0x71. done pulses are spaced 25 cycles apart (24 conversion cycles + 1 DONE); busy is low only in the DONE cycles.
4. Abort mid-conversion at bit 4 with result previously 0x3C -> next edge IDLE, busy=0, dac_code=0, no done pulse, result stays 0x3C. A start pulse while busy has no effect on timing or result.
5. rst asserted mid-conversion, and also simultaneously with start -> all outputs 0 on the next cycle, state IDLE; a conversion started afterwards completes normally.
6. Parameter sweep N=4, SETTLE=0, vin=0x9 -> done 4 edges after start, result=0x9. Also verify cmp is ignored on non-decision edges at SETTLE=3 by toggling it between decisions.
